m_pmu_ctrl: RTL and testbench
=============================

# m_pmu_ctrl

Power-management controller that drives the CPU sequencer's sleep/wake handshake from the requesting side. It counts idle cycles, raises `sleep_request` after a programmable timeout, and waits for the CPU to report its SLEEP state before gating the core clock. On an unmasked wake event it ungates the clock and holds `wakeup_request` until the CPU reports ACTIVE. It sits beside the CPU FSM on the always-on clock, and its outputs feed the CPU FSM request inputs and the core clock gate.

## Interface
- `IDLE_TIMEOUT`, 16: consecutive activity-free cycles before a sleep request; legal range 1..65535.
- `ACK_TIMEOUT`, 64: cycles to wait for a CPU handshake acknowledge before flagging an error.
- `N_WAKE`, 4: number of wake-event sources.
- `clk` in 1: always-on clock; never gated.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `cpu_state` in 3: CPU FSM state code (IDLE 000, ACTIVE 001, FETCH 010, EXECUTE 011, DECODE 100, SLEEP 101).
- `activity` in 1: bus/instruction activity, level-sampled each cycle.
- `sleep_en` in 1: 0 holds the idle counter at 0, so no sleep request is made.
- `wake_event` in N_WAKE: level wake sources.
- `wake_mask` in N_WAKE: 1 enables the corresponding source.
- `err_clr` in 1: clears `err_timeout`.
- `sleep_request` out 1: request to the CPU FSM to enter SLEEP.
- `wakeup_request` out 1: request to the CPU FSM to leave SLEEP.
- `clk_gate_en` out 1: core clock enable; 1 means the clock runs.
- `wake_cause` out N_WAKE: unmasked wake sources captured at wake.
- `wake_irq` out 1: one-cycle pulse when a wake completes.
- `err_timeout` out 1: sticky handshake-timeout flag.
- `pmu_state` out 2: current PMU state, for debug.

## Operation
- The PMU has four states: RUN 00, REQ_SLEEP 01, ASLEEP 10, REQ_WAKE 11.
- `wake_hit` is defined as `|(wake_event & wake_mask)`.
- Reset values: state RUN; `sleep_request`, `wakeup_request`, `wake_irq` and `err_timeout` 0; `clk_gate_en` 1; `wake_cause` 0; all counters 0.
- **RUN**
  - The idle counter clears on `activity`=1, `sleep_en`=0 or `wake_hit`; otherwise it increments and saturates at IDLE_TIMEOUT.
  - When the counter reaches IDLE_TIMEOUT, the state goes to REQ_SLEEP and `sleep_request` is set to 1.
- **REQ_SLEEP**
  - `sleep_request` is held high and the ack counter increments.
  - Transition priority is:
    1. `wake_hit` or `activity`: abort to RUN, `sleep_request` goes to 0, and the idle counter clears.
    2. `cpu_state`==SLEEP: go to ASLEEP, `sleep_request` goes to 0, `clk_gate_en` goes to 0.
    3. Ack counter reaches ACK_TIMEOUT: go to RUN, `sleep_request` goes to 0, `err_timeout` goes to 1.
- **ASLEEP**
  - `clk_gate_en` stays 0.
  - `wake_hit` moves the state to REQ_WAKE, sets `clk_gate_en` to 1 and `wakeup_request` to 1, and loads `wake_cause` with `wake_event & wake_mask`.
  - `activity` is ignored in this state.
- **REQ_WAKE**
  - `wakeup_request` is held high and the ack counter increments.
  - `cpu_state`==ACTIVE moves the state to RUN, sets `wakeup_request` to 0, and pulses `wake_irq` for one cycle.
  - When the ack counter reaches ACK_TIMEOUT, `err_timeout` goes to 1, the ack counter restarts, and `wakeup_request` stays high (the PMU retries indefinitely).
- The ack counter clears on every state change.
- `sleep_request` and `wakeup_request` are never high together.
- `wake_cause` holds its value until the next wake capture; it is not cleared by returning to RUN.
- `err_clr` clears `err_timeout`. If a timeout and `err_clr` occur in the same cycle, the timeout wins.
- Asserting reset mid-handshake forces all reset values immediately (asynchronously), including `clk_gate_en`=1.

## Timing
- All outputs are registered.
- `sleep_request` rises on the edge at which the count of consecutive qualifying idle cycles reaches IDLE_TIMEOUT, i.e. IDLE_TIMEOUT edges after the last `activity` sample.
- The CPU acknowledge is sampled one cycle after the request rises at the earliest. The response (request drop, gate change) lands on the same edge that samples the acknowledge.
- From `wake_hit` sampled in ASLEEP, `clk_gate_en` and `wakeup_request` both rise on the next edge (1-cycle latency).
- `wake_irq` is high for exactly one cycle, on the edge where ACTIVE is sampled in REQ_WAKE.
- The core clock gate must be glitch-free; it is implemented downstream with a latch-based ICG. The PMU only supplies the enable.

## Structure
- The shared package `cpu_pkg` holds:
  - the CPU state codes (IDLE, ACTIVE, FETCH, EXECUTE, DECODE, SLEEP);
  - the PMU state enum;
  - the status flag bit constants.
- The CPU FSM uses the same package so that the state codes match exactly.
- One sub-module, `m_pmu_timer`: a saturating up-counter with clear, enable and a terminal-count compare. It is instantiated twice, once for the idle counter and once for the ack counter.

## Test plan
- Idle entry: IDLE_TIMEOUT=16, `activity` low from cycle 0 → `sleep_request` high after edge 16. `cpu_state`=101 at cycle 20 → `sleep_request`=0 and `clk_gate_en`=0 at edge 21, `pmu_state`=10.
- Wake: in ASLEEP with `wake_mask`=0101, `wake_event`=0100 → next edge `clk_gate_en`=1, `wakeup_request`=1, `wake_cause`=0100. `cpu_state`=001 three cycles later → `wake_irq` pulses for 1 cycle and `pmu_state`=00.
- Masked wake: in ASLEEP with `wake_mask`=0000, `wake_event`=1111 → the PMU stays in ASLEEP and `clk_gate_en` remains 0.
- Abort: in REQ_SLEEP, `activity`=1 for one cycle → `sleep_request`=0 on the next edge, state RUN, and a new 16-cycle idle count before re-request.
- Timeout: ACK_TIMEOUT=64 and `cpu_state` held at 010 in REQ_SLEEP → after 64 cycles `err_timeout`=1 and state RUN. `err_clr` pulse → `err_timeout`=0.
- Reset mid-REQ_WAKE: `reset` low → `wakeup_request`=0, `clk_gate_en`=1 and `pmu_state`=00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer and the power-management controller.
// The CPU state codes here are the ones the CPU FSM drives on its state output.
package cpu_pkg;

    typedef enum logic [2:0] {
        CPU_IDLE    = 3'b000,
        CPU_ACTIVE  = 3'b001,
        CPU_FETCH   = 3'b010,
        CPU_EXECUTE = 3'b011,
        CPU_DECODE  = 3'b100,
        CPU_SLEEP   = 3'b101
    } cpu_state_e;

    typedef enum logic [1:0] {
        PMU_RUN       = 2'b00,
        PMU_REQ_SLEEP = 2'b01,
        PMU_ASLEEP    = 2'b10,
        PMU_REQ_WAKE  = 2'b11
    } pmu_state_e;

    // Bit positions of the PMU status flags in a packed status word.
    localparam int unsigned STAT_SLEEP_REQ = 0;
    localparam int unsigned STAT_WAKE_REQ  = 1;
    localparam int unsigned STAT_CLK_EN    = 2;
    localparam int unsigned STAT_WAKE_IRQ  = 3;
    localparam int unsigned STAT_ERR_TO    = 4;

    function automatic logic is_handshake(input pmu_state_e s);
        return (s == PMU_REQ_SLEEP) || (s == PMU_REQ_WAKE);
    endfunction

endpackage

// File: rtl/m_pmu_timer.sv
// Saturating up-counter with clear and enable. o_hit flags that the current
// increment lands on LIMIT, so a caller can act on the same edge.
module m_pmu_timer #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam logic [WIDTH-1:0] TOP  = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != TOP)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Independent of i_clr so the caller may derive i_clr from o_hit.
    assign o_hit = i_en && (r_count == LAST);

endmodule

// File: rtl/m_pmu_ctrl.sv
// Power-management controller: idle-timeout sleep request, CPU sleep/wake
// handshake, core clock-gate enable and wake-cause capture.
module m_pmu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 16,
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned N_WAKE       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cpu_state,
    input  logic              activity,
    input  logic              sleep_en,
    input  logic [N_WAKE-1:0] wake_event,
    input  logic [N_WAKE-1:0] wake_mask,
    input  logic              err_clr,
    output logic              sleep_request,
    output logic              wakeup_request,
    output logic              clk_gate_en,
    output logic [N_WAKE-1:0] wake_cause,
    output logic              wake_irq,
    output logic              err_timeout,
    output logic [1:0]        pmu_state
);

    pmu_state_e        r_state, w_next;
    logic              r_sleep_req, r_wake_req, r_gate_en, r_wake_irq, r_err;
    logic [N_WAKE-1:0] r_wake_cause;

    logic              w_sleep_req, w_wake_req, w_gate_en, w_wake_irq, w_err;
    logic [N_WAKE-1:0] w_wake_cause;
    logic              w_wake_hit, w_idle_en, w_idle_hit;
    logic              w_ack_en, w_ack_clr, w_ack_hit, w_ack_restart;

    assign w_wake_hit = |(wake_event & wake_mask);
    assign w_idle_en  = (r_state == PMU_RUN) && !activity && sleep_en && !w_wake_hit;
    assign w_ack_en   = is_handshake(r_state);
    assign w_ack_clr  = w_ack_restart || (w_next != r_state) || !w_ack_en;

    m_pmu_timer #(.LIMIT(IDLE_TIMEOUT)) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (!w_idle_en),
        .i_en  (w_idle_en),
        .o_hit (w_idle_hit)
    );

    m_pmu_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_ack_clr),
        .i_en  (w_ack_en),
        .o_hit (w_ack_hit)
    );

    always_comb begin
        w_next        = r_state;
        w_sleep_req   = r_sleep_req;
        w_wake_req    = r_wake_req;
        w_gate_en     = r_gate_en;
        w_wake_cause  = r_wake_cause;
        w_wake_irq    = 1'b0;
        w_err         = r_err && !err_clr;
        w_ack_restart = 1'b0;
        case (r_state)
            PMU_RUN: begin
                if (w_idle_hit) begin
                    w_next      = PMU_REQ_SLEEP;
                    w_sleep_req = 1'b1;
                end
            end
            PMU_REQ_SLEEP: begin
                if (w_wake_hit || activity) begin
                    w_next      = PMU_RUN;
                    w_sleep_req = 1'b0;
                end else if (cpu_state == CPU_SLEEP) begin
                    w_next      = PMU_ASLEEP;
                    w_sleep_req = 1'b0;
                    w_gate_en   = 1'b0;
                end else if (w_ack_hit) begin
                    w_next      = PMU_RUN;
                    w_sleep_req = 1'b0;
                    w_err       = 1'b1;
                end
            end
            PMU_ASLEEP: begin
                if (w_wake_hit) begin
                    w_next       = PMU_REQ_WAKE;
                    w_gate_en    = 1'b1;
                    w_wake_req   = 1'b1;
                    w_wake_cause = wake_event & wake_mask;
                end
            end
            PMU_REQ_WAKE: begin
                // An acknowledge on the timeout edge completes the wake without flagging.
                if (cpu_state == CPU_ACTIVE) begin
                    w_next     = PMU_RUN;
                    w_wake_req = 1'b0;
                    w_wake_irq = 1'b1;
                end else if (w_ack_hit) begin
                    w_err         = 1'b1;
                    w_ack_restart = 1'b1;
                end
            end
            default: w_next = PMU_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= PMU_RUN;
            r_sleep_req  <= 1'b0;
            r_wake_req   <= 1'b0;
            r_gate_en    <= 1'b1;
            r_wake_cause <= '0;
            r_wake_irq   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_sleep_req  <= w_sleep_req;
            r_wake_req   <= w_wake_req;
            r_gate_en    <= w_gate_en;
            r_wake_cause <= w_wake_cause;
            r_wake_irq   <= w_wake_irq;
            r_err        <= w_err;
        end
    end

    assign sleep_request  = r_sleep_req;
    assign wakeup_request = r_wake_req;
    assign clk_gate_en    = r_gate_en;
    assign wake_cause     = r_wake_cause;
    assign wake_irq       = r_wake_irq;
    assign err_timeout    = r_err;
    assign pmu_state      = r_state;

endmodule

// File: tb/tb_m_pmu_ctrl.sv
// Scoreboard bench for m_pmu_ctrl: a behavioural model queues the expected
// outputs per clock edge and a monitor compares them after each edge.
module tb_m_pmu_ctrl;

    localparam int unsigned IT = 16;
    localparam int unsigned AT = 64;
    localparam int unsigned NW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    cpu_state = 3'd0;
    logic          activity = 1'b0;
    logic          sleep_en = 1'b0;
    logic [NW-1:0] wake_event = '0;
    logic [NW-1:0] wake_mask = '0;
    logic          err_clr = 1'b0;
    logic          sleep_request, wakeup_request, clk_gate_en, wake_irq, err_timeout;
    logic [NW-1:0] wake_cause;
    logic [1:0]    pmu_state;

    m_pmu_ctrl #(.IDLE_TIMEOUT(IT), .ACK_TIMEOUT(AT), .N_WAKE(NW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_state      (cpu_state),
        .activity       (activity),
        .sleep_en       (sleep_en),
        .wake_event     (wake_event),
        .wake_mask      (wake_mask),
        .err_clr        (err_clr),
        .sleep_request  (sleep_request),
        .wakeup_request (wakeup_request),
        .clk_gate_en    (clk_gate_en),
        .wake_cause     (wake_cause),
        .wake_irq       (wake_irq),
        .err_timeout    (err_timeout),
        .pmu_state      (pmu_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sreq;
        logic          wreq;
        logic          gate;
        logic [NW-1:0] cause;
        logic          irq;
        logic          err;
        logic [1:0]    st;
    } obs_t;

    localparam obs_t RESET_OBS = '{sreq: 1'b0, wreq: 1'b0, gate: 1'b1, cause: '0,
                                   irq: 1'b0, err: 1'b0, st: 2'b00};

    obs_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference model: mode 0 RUN, 1 REQ_SLEEP, 2 ASLEEP, 3 REQ_WAKE.
    int unsigned   m_mode, m_idle, m_ack;
    logic          m_sreq, m_wreq, m_gate, m_irq, m_err;
    logic [NW-1:0] m_cause;

    task automatic model_reset();
        m_mode = 0; m_idle = 0; m_ack = 0;
        m_sreq = 1'b0; m_wreq = 1'b0; m_gate = 1'b1; m_irq = 1'b0; m_err = 1'b0;
        m_cause = '0;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.sreq = m_sreq; o.wreq = m_wreq; o.gate = m_gate; o.cause = m_cause;
        o.irq = m_irq; o.err = m_err; o.st = 2'(m_mode);
        return o;
    endfunction

    task automatic model_step(input logic act, input logic sen, input logic [NW-1:0] ev,
                              input logic [NW-1:0] mk, input logic [2:0] cpu, input logic clr);
        bit hit;
        hit = ((ev & mk) != 0);
        m_irq = 1'b0;
        if (clr) m_err = 1'b0;
        case (m_mode)
            0: begin
                if (act || !sen || hit) m_idle = 0;
                else if (m_idle < IT) m_idle = m_idle + 1;
                if (m_idle == IT) begin
                    m_mode = 1; m_sreq = 1'b1; m_idle = 0; m_ack = 0;
                end
            end
            1: begin
                m_ack = m_ack + 1;
                if (act || hit) begin
                    m_mode = 0; m_sreq = 1'b0; m_ack = 0; m_idle = 0;
                end else if (cpu == 3'd5) begin
                    m_mode = 2; m_sreq = 1'b0; m_gate = 1'b0; m_ack = 0;
                end else if (m_ack == AT) begin
                    m_mode = 0; m_sreq = 1'b0; m_err = 1'b1; m_ack = 0; m_idle = 0;
                end
            end
            2: begin
                if (hit) begin
                    m_mode = 3; m_gate = 1'b1; m_wreq = 1'b1; m_cause = ev & mk; m_ack = 0;
                end
            end
            default: begin
                m_ack = m_ack + 1;
                if (cpu == 3'd1) begin
                    m_mode = 0; m_wreq = 1'b0; m_irq = 1'b1; m_ack = 0; m_idle = 0;
                end else if (m_ack == AT) begin
                    m_err = 1'b1; m_ack = 0;
                end
            end
        endcase
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.sreq = sleep_request; o.wreq = wakeup_request; o.gate = clk_gate_en;
        o.cause = wake_cause; o.irq = wake_irq; o.err = err_timeout; o.st = pmu_state;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t e);
        obs_t a;
        a = dut_obs();
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got sreq=%b wreq=%b gate=%b cause=%b irq=%b err=%b st=%b, expected sreq=%b wreq=%b gate=%b cause=%b irq=%b err=%b st=%b",
                     name, $time, a.sreq, a.wreq, a.gate, a.cause, a.irq, a.err, a.st,
                     e.sreq, e.wreq, e.gate, e.cause, e.irq, e.err, e.st);
        end
    endtask

    // Called at a falling edge: apply inputs, queue the model's view of the next edge.
    task automatic drive(input logic act, input logic sen, input logic [NW-1:0] ev,
                         input logic [NW-1:0] mk, input logic [2:0] cpu, input logic clr);
        activity = act; sleep_en = sen; wake_event = ev; wake_mask = mk;
        cpu_state = cpu; err_clr = clr;
        model_step(act, sen, ev, mk, cpu, clr);
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic reset_mid();
        #2 reset = 1'b0;
        #1 check_obs("async_reset", RESET_OBS);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_obs("outputs", e);
            end
        end
    end

    initial begin : stimulus
        logic          r_act, r_sen, r_clr;
        logic [NW-1:0] r_ev, r_mk;
        logic [2:0]    r_cpu;

        model_reset();
        repeat (2) @(posedge clk);
        #1 check_obs("reset_state", RESET_OBS);
        @(negedge clk);
        reset = 1'b1;

        // Idle entry, then CPU reports SLEEP on the 21st edge.
        repeat (20) drive(1'b0, 1'b1, 4'h0, 4'h0, 3'd0, 1'b0);
        drive(1'b0, 1'b1, 4'h0, 4'h0, 3'd5, 1'b0);
        // Masked wake sources and activity must not disturb ASLEEP.
        repeat (5) drive(1'b0, 1'b1, 4'hF, 4'h0, 3'd5, 1'b0);
        repeat (2) drive(1'b1, 1'b1, 4'h0, 4'h0, 3'd5, 1'b0);
        // Unmasked wake, CPU ACTIVE three cycles later.
        drive(1'b0, 1'b1, 4'b0100, 4'b0101, 3'd5, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 4'h0, 4'b0101, 3'd5, 1'b0);
        drive(1'b0, 1'b1, 4'h0, 4'b0101, 3'd1, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 4'h0, 4'b0101, 3'd1, 1'b0);
        // Sleep request, abort on activity, fresh idle count, then ack timeout.
        repeat (16) drive(1'b0, 1'b1, 4'h0, 4'h0, 3'd1, 1'b0);
        drive(1'b1, 1'b1, 4'h0, 4'h0, 3'd1, 1'b0);
        repeat (16) drive(1'b0, 1'b1, 4'h0, 4'h0, 3'd2, 1'b0);
        repeat (70) drive(1'b0, 1'b1, 4'h0, 4'h0, 3'd2, 1'b0);
        drive(1'b0, 1'b1, 4'h0, 4'h0, 3'd2, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 4'h0, 4'h0, 3'd2, 1'b0);
        // Wake handshake timeout, with err_clr on the timeout edge (timeout wins).
        repeat (16) drive(1'b0, 1'b1, 4'h0, 4'h0, 3'd0, 1'b0);
        drive(1'b0, 1'b1, 4'h0, 4'h0, 3'd5, 1'b0);
        drive(1'b0, 1'b1, 4'b1000, 4'b1001, 3'd5, 1'b0);
        repeat (63) drive(1'b0, 1'b1, 4'h0, 4'b1001, 3'd5, 1'b0);
        drive(1'b0, 1'b1, 4'h0, 4'b1001, 3'd5, 1'b1);
        repeat (10) drive(1'b0, 1'b1, 4'h0, 4'b1001, 3'd5, 1'b1);
        reset_mid();

        for (int i = 0; i < 3000; i++) begin
            r_act = ($urandom_range(0, 11) == 0);
            r_sen = ($urandom_range(0, 19) != 0);
            r_mk  = NW'($urandom);
            r_ev  = ($urandom_range(0, 9) == 0) ? NW'($urandom) : '0;
            r_clr = ($urandom_range(0, 15) == 0);
            case (m_mode)
                1:       r_cpu = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom_range(0, 4));
                3:       r_cpu = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd5;
                default: r_cpu = 3'($urandom_range(0, 5));
            endcase
            if (i == 1500) reset_mid();
            drive(r_act, r_sen, r_ev, r_mk, r_cpu, r_clr);
        end

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
